// File: rtl/bp_me_stream_mem_arbiter.sv
// bp_me_stream_mem_arbiter
//   Merges the I$ (requester 0) and D$ (requester 1) BedRock stream memory
//   command buses onto one memory port and routes each memory response back
//   to the requester that issued the matching command. Arbitration is
//   round-robin per message; a multi-beat command keeps the grant until its
//   last beat. The memory answers in command order, so a small tag FIFO of
//   requester ids is enough to steer responses.
//
// Ports
//   clk_i, reset_n_i          single clock, async active-low reset
//   req_cmd_*                 two packed requester command channels (header + data)
//   mem_cmd_*                 merged command channel towards memory
//   mem_resp_*                shared response channel from memory
//   req_resp_*                two packed requester response channels
//   Packed 2x buses carry requester i in slice [i*W +: W].
//
// States
//   C_IDLE | accepting a command header from the granted requester
//   C_DATA | streaming data beats of the registered grant until last
//   R_IDLE | waiting for a response header, steered by the tag FIFO head
//   R_DATA | streaming response beats to the registered target until last

module bp_me_stream_mem_arbiter #(
  parameter int header_width_p = 64,
  parameter int dword_width_p  = 64,
  parameter int fill_width_p   = 64,
  parameter int outstanding_p  = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic [2*header_width_p-1:0] req_cmd_header_i,
  input  logic [2*dword_width_p-1:0]  req_cmd_critical_i,
  input  logic [1:0]                  req_cmd_header_v_i,
  output logic [1:0]                  req_cmd_header_ready_and_o,
  input  logic [1:0]                  req_cmd_has_data_i,
  input  logic [2*fill_width_p-1:0]   req_cmd_data_i,
  input  logic [1:0]                  req_cmd_data_v_i,
  output logic [1:0]                  req_cmd_data_ready_and_o,
  input  logic [1:0]                  req_cmd_last_i,

  output logic [header_width_p-1:0]   mem_cmd_header_o,
  output logic [dword_width_p-1:0]    mem_cmd_critical_o,
  output logic                        mem_cmd_header_v_o,
  output logic                        mem_cmd_has_data_o,
  input  logic                        mem_cmd_header_ready_and_i,
  output logic [fill_width_p-1:0]     mem_cmd_data_o,
  output logic                        mem_cmd_data_v_o,
  output logic                        mem_cmd_last_o,
  input  logic                        mem_cmd_data_ready_and_i,

  input  logic [header_width_p-1:0]   mem_resp_header_i,
  input  logic [dword_width_p-1:0]    mem_resp_critical_i,
  input  logic                        mem_resp_header_v_i,
  input  logic                        mem_resp_has_data_i,
  output logic                        mem_resp_header_ready_and_o,
  input  logic [fill_width_p-1:0]     mem_resp_data_i,
  input  logic                        mem_resp_data_v_i,
  input  logic                        mem_resp_last_i,
  output logic                        mem_resp_data_ready_and_o,

  output logic [2*header_width_p-1:0] req_resp_header_o,
  output logic [2*dword_width_p-1:0]  req_resp_critical_o,
  output logic [1:0]                  req_resp_header_v_o,
  output logic [1:0]                  req_resp_has_data_o,
  input  logic [1:0]                  req_resp_header_ready_and_i,
  output logic [2*fill_width_p-1:0]   req_resp_data_o,
  output logic [1:0]                  req_resp_data_v_o,
  output logic [1:0]                  req_resp_last_o,
  input  logic [1:0]                  req_resp_data_ready_and_i
);

  localparam logic [0:0] C_IDLE = 1'b0;
  localparam logic [0:0] C_DATA = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam int PTR_W = $clog2(outstanding_p);
  localparam int CNT_W = $clog2(outstanding_p + 1);

  logic [0:0]               r_cstate;
  logic [0:0]               r_rstate;
  logic                     r_rr_ptr;
  logic                     r_cmd_gnt;
  logic                     r_resp_tgt;
  logic [outstanding_p-1:0] r_tags;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;

  logic       w_full;
  logic       w_empty;
  logic       w_cmd_idle;
  logic       w_cmd_data;
  logic       w_resp_idle;
  logic       w_resp_data;
  logic [1:0] w_elig;
  logic       w_grant;
  logic       w_head;
  logic       w_push;
  logic       w_pop;
  logic       w_cmd_data_done;
  logic       w_resp_data_done;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(outstanding_p - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full  = (r_count == CNT_W'(outstanding_p));
  assign w_empty = (r_count == '0);
  assign w_head  = r_tags[r_rd_ptr];

  // Outputs are gated with reset_n_i so every valid/ready drops as soon as
  // reset asserts, not at the next edge.
  assign w_cmd_idle  = reset_n_i & (r_cstate == C_IDLE);
  assign w_cmd_data  = reset_n_i & (r_cstate == C_DATA);
  assign w_resp_idle = reset_n_i & (r_rstate == R_IDLE);
  assign w_resp_data = reset_n_i & (r_rstate == R_DATA);

  // A full tag FIFO makes nobody eligible; a pop in the same cycle does not
  // help until the next cycle.
  assign w_elig  = req_cmd_header_v_i & {2{~w_full}};
  assign w_grant = w_elig[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;

  always_comb begin
    mem_cmd_header_o           = '0;
    mem_cmd_critical_o         = '0;
    mem_cmd_has_data_o         = 1'b0;
    mem_cmd_header_v_o         = 1'b0;
    mem_cmd_data_o             = '0;
    mem_cmd_data_v_o           = 1'b0;
    mem_cmd_last_o             = 1'b0;
    req_cmd_header_ready_and_o = '0;
    req_cmd_data_ready_and_o   = '0;
    if (w_cmd_idle) begin
      mem_cmd_header_o   = w_grant ? req_cmd_header_i[2*header_width_p-1:header_width_p]
                                   : req_cmd_header_i[header_width_p-1:0];
      mem_cmd_critical_o = w_grant ? req_cmd_critical_i[2*dword_width_p-1:dword_width_p]
                                   : req_cmd_critical_i[dword_width_p-1:0];
      mem_cmd_has_data_o = req_cmd_has_data_i[w_grant];
      mem_cmd_header_v_o = |w_elig;
      req_cmd_header_ready_and_o[w_grant] = mem_cmd_header_ready_and_i & ~w_full;
    end else if (w_cmd_data) begin
      mem_cmd_data_o   = r_cmd_gnt ? req_cmd_data_i[2*fill_width_p-1:fill_width_p]
                                   : req_cmd_data_i[fill_width_p-1:0];
      mem_cmd_data_v_o = req_cmd_data_v_i[r_cmd_gnt];
      mem_cmd_last_o   = req_cmd_last_i[r_cmd_gnt];
      req_cmd_data_ready_and_o[r_cmd_gnt] = mem_cmd_data_ready_and_i;
    end
  end

  // Response payload is broadcast; only the valids are steered.
  always_comb begin
    req_resp_header_o           = '0;
    req_resp_critical_o         = '0;
    req_resp_has_data_o         = '0;
    req_resp_data_o             = '0;
    req_resp_last_o             = '0;
    req_resp_header_v_o         = '0;
    req_resp_data_v_o           = '0;
    mem_resp_header_ready_and_o = 1'b0;
    mem_resp_data_ready_and_o   = 1'b0;
    if (reset_n_i) begin
      req_resp_header_o   = {2{mem_resp_header_i}};
      req_resp_critical_o = {2{mem_resp_critical_i}};
      req_resp_has_data_o = {2{mem_resp_has_data_i}};
      req_resp_data_o     = {2{mem_resp_data_i}};
      req_resp_last_o     = {2{mem_resp_last_i}};
    end
    if (w_resp_idle && !w_empty) begin
      mem_resp_header_ready_and_o  = req_resp_header_ready_and_i[w_head];
      req_resp_header_v_o[w_head]  = mem_resp_header_v_i;
    end else if (w_resp_data) begin
      mem_resp_data_ready_and_o    = req_resp_data_ready_and_i[r_resp_tgt];
      req_resp_data_v_o[r_resp_tgt] = mem_resp_data_v_i;
    end
  end

  assign w_push           = mem_cmd_header_v_o & mem_cmd_header_ready_and_i;
  assign w_pop            = mem_resp_header_v_i & mem_resp_header_ready_and_o;
  assign w_cmd_data_done  = mem_cmd_data_v_o & mem_cmd_data_ready_and_i & mem_cmd_last_o;
  assign w_resp_data_done = mem_resp_data_v_i & mem_resp_data_ready_and_o & mem_resp_last_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cstate  <= C_IDLE;
      r_rr_ptr  <= 1'b0;
      r_cmd_gnt <= 1'b0;
    end else begin
      case (r_cstate)
        C_IDLE: if (w_push) begin
          r_rr_ptr <= ~w_grant;
          if (req_cmd_has_data_i[w_grant]) begin
            r_cmd_gnt <= w_grant;
            r_cstate  <= C_DATA;
          end
        end
        default: if (w_cmd_data_done) r_cstate <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rstate   <= R_IDLE;
      r_resp_tgt <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: if (w_pop && mem_resp_has_data_i) begin
          r_resp_tgt <= w_head;
          r_rstate   <= R_DATA;
        end
        default: if (w_resp_data_done) r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_tags   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_tags[r_wr_ptr] <= w_grant;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A response with no outstanding tag is held (ready stays low), never dropped.
  a_resp_without_tag: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (r_rstate == R_IDLE && mem_resp_header_v_i) |-> !w_empty);

endmodule

// File: tb/tb_bp_me_stream_mem_arbiter.sv
module tb_bp_me_stream_mem_arbiter;
  localparam int HW = 64;
  localparam int DW = 64;
  localparam int FW = 64;
  localparam logic [HW-1:0] H0 = 64'hA000_0000_0000_00A0;
  localparam logic [HW-1:0] H1 = 64'hB111_0000_0000_00B1;
  localparam logic [DW-1:0] C0 = 64'hC0C0;
  localparam logic [DW-1:0] C1 = 64'hC1C1;

  logic clk_i = 1'b0;
  logic reset_n_i;
  logic [2*HW-1:0] req_cmd_header_i;
  logic [2*DW-1:0] req_cmd_critical_i;
  logic [1:0]      req_cmd_header_v_i, req_cmd_header_ready_and_o, req_cmd_has_data_i;
  logic [2*FW-1:0] req_cmd_data_i;
  logic [1:0]      req_cmd_data_v_i, req_cmd_data_ready_and_o, req_cmd_last_i;
  logic [HW-1:0]   mem_cmd_header_o;
  logic [DW-1:0]   mem_cmd_critical_o;
  logic            mem_cmd_header_v_o, mem_cmd_has_data_o, mem_cmd_header_ready_and_i;
  logic [FW-1:0]   mem_cmd_data_o;
  logic            mem_cmd_data_v_o, mem_cmd_last_o, mem_cmd_data_ready_and_i;
  logic [HW-1:0]   mem_resp_header_i;
  logic [DW-1:0]   mem_resp_critical_i;
  logic            mem_resp_header_v_i, mem_resp_has_data_i, mem_resp_header_ready_and_o;
  logic [FW-1:0]   mem_resp_data_i;
  logic            mem_resp_data_v_i, mem_resp_last_i, mem_resp_data_ready_and_o;
  logic [2*HW-1:0] req_resp_header_o;
  logic [2*DW-1:0] req_resp_critical_o;
  logic [1:0]      req_resp_header_v_o, req_resp_has_data_o, req_resp_header_ready_and_i;
  logic [2*FW-1:0] req_resp_data_o;
  logic [1:0]      req_resp_data_v_o, req_resp_last_o, req_resp_data_ready_and_i;

  bp_me_stream_mem_arbiter #(
    .header_width_p(HW), .dword_width_p(DW), .fill_width_p(FW), .outstanding_p(4)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_cmd_header_i(req_cmd_header_i), .req_cmd_critical_i(req_cmd_critical_i),
    .req_cmd_header_v_i(req_cmd_header_v_i), .req_cmd_header_ready_and_o(req_cmd_header_ready_and_o),
    .req_cmd_has_data_i(req_cmd_has_data_i), .req_cmd_data_i(req_cmd_data_i),
    .req_cmd_data_v_i(req_cmd_data_v_i), .req_cmd_data_ready_and_o(req_cmd_data_ready_and_o),
    .req_cmd_last_i(req_cmd_last_i),
    .mem_cmd_header_o(mem_cmd_header_o), .mem_cmd_critical_o(mem_cmd_critical_o),
    .mem_cmd_header_v_o(mem_cmd_header_v_o), .mem_cmd_has_data_o(mem_cmd_has_data_o),
    .mem_cmd_header_ready_and_i(mem_cmd_header_ready_and_i),
    .mem_cmd_data_o(mem_cmd_data_o), .mem_cmd_data_v_o(mem_cmd_data_v_o),
    .mem_cmd_last_o(mem_cmd_last_o), .mem_cmd_data_ready_and_i(mem_cmd_data_ready_and_i),
    .mem_resp_header_i(mem_resp_header_i), .mem_resp_critical_i(mem_resp_critical_i),
    .mem_resp_header_v_i(mem_resp_header_v_i), .mem_resp_has_data_i(mem_resp_has_data_i),
    .mem_resp_header_ready_and_o(mem_resp_header_ready_and_o),
    .mem_resp_data_i(mem_resp_data_i), .mem_resp_data_v_i(mem_resp_data_v_i),
    .mem_resp_last_i(mem_resp_last_i), .mem_resp_data_ready_and_o(mem_resp_data_ready_and_o),
    .req_resp_header_o(req_resp_header_o), .req_resp_critical_o(req_resp_critical_o),
    .req_resp_header_v_o(req_resp_header_v_o), .req_resp_has_data_o(req_resp_has_data_o),
    .req_resp_header_ready_and_i(req_resp_header_ready_and_i),
    .req_resp_data_o(req_resp_data_o), .req_resp_data_v_o(req_resp_data_v_o),
    .req_resp_last_o(req_resp_last_o), .req_resp_data_ready_and_i(req_resp_data_ready_and_i)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_n_i = 1'b0;
    req_cmd_header_i   = {H1, H0};
    req_cmd_critical_i = {C1, C0};
    req_cmd_header_v_i = 2'b11;
    req_cmd_has_data_i = 2'b00;
    req_cmd_data_i     = '0;
    req_cmd_data_v_i   = 2'b00;
    req_cmd_last_i     = 2'b00;
    mem_cmd_header_ready_and_i = 1'b1;
    mem_cmd_data_ready_and_i   = 1'b1;
    mem_resp_header_i   = '0;
    mem_resp_critical_i = '0;
    mem_resp_header_v_i = 1'b0;
    mem_resp_has_data_i = 1'b0;
    mem_resp_data_i     = '0;
    mem_resp_data_v_i   = 1'b0;
    mem_resp_last_i     = 1'b0;
    req_resp_header_ready_and_i = 2'b11;
    req_resp_data_ready_and_i   = 2'b11;

    // reset: outputs low even though both requesters are valid
    #2;
    chk("rst_mem_hdr_v", 64'(mem_cmd_header_v_o), 64'd0);
    chk("rst_req_hdr_rdy", 64'(req_cmd_header_ready_and_o), 64'd0);
    chk("rst_resp_hdr_rdy", 64'(mem_resp_header_ready_and_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #3 reset_n_i = 1'b1;
    #1;

    // round robin until the 4-deep tag FIFO fills: grants 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      chk("rr_ready", 64'(req_cmd_header_ready_and_o), (i % 2) ? 64'd2 : 64'd1);
      chk("rr_hdr", 64'(mem_cmd_header_o), (i % 2) ? 64'(H1) : 64'(H0));
      chk("rr_crit", 64'(mem_cmd_critical_o), (i % 2) ? 64'(C1) : 64'(C0));
      cyc();
    end
    chk("full_ready", 64'(req_cmd_header_ready_and_o), 64'd0);
    chk("full_hdr_v", 64'(mem_cmd_header_v_o), 64'd0);

    // pop one while full: push still blocked this cycle, allowed the next
    mem_resp_header_v_i = 1'b1;
    mem_resp_header_i   = 64'h5E;
    #1;
    chk("pop0_tgt", 64'(req_resp_header_v_o), 64'd1);
    chk("pop0_rdy", 64'(mem_resp_header_ready_and_o), 64'd1);
    chk("pop_full_blk", 64'(req_cmd_header_ready_and_o), 64'd0);
    cyc();
    mem_resp_header_v_i = 1'b0;
    #1;
    chk("after_pop_rdy", 64'(req_cmd_header_ready_and_o), 64'd1);
    cyc();
    req_cmd_header_v_i = 2'b00;

    // FIFO now holds 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      mem_resp_header_v_i = 1'b1;
      #1;
      chk("drain_tgt", 64'(req_resp_header_v_o), (i % 2) ? 64'd1 : 64'd2);
      cyc();
    end
    mem_resp_header_v_i = 1'b0;

    // requester 1 4-beat write; requester 0 header arrives one cycle later
    req_cmd_header_v_i = 2'b10;
    req_cmd_has_data_i = 2'b10;
    #1;
    chk("wr_hdr_rdy", 64'(req_cmd_header_ready_and_o), 64'd2);
    chk("wr_has_data", 64'(mem_cmd_has_data_o), 64'd1);
    chk("wr_no_data_yet", 64'(mem_cmd_data_v_o), 64'd0);
    cyc();
    req_cmd_header_v_i = 2'b01;
    req_cmd_has_data_i = 2'b00;
    for (int b = 0; b < 4; b++) begin
      req_cmd_data_i   = {64'hD000 + 64'(b), 64'h0BAD};
      req_cmd_data_v_i = 2'b10;
      req_cmd_last_i   = (b == 3) ? 2'b10 : 2'b00;
      #1;
      chk("wr_beat_v", 64'(mem_cmd_data_v_o), 64'd1);
      chk("wr_beat_d", mem_cmd_data_o, 64'hD000 + 64'(b));
      chk("wr_beat_rdy", 64'(req_cmd_data_ready_and_o), 64'd2);
      chk("wr_hdr_blocked", 64'(req_cmd_header_ready_and_o), 64'd0);
      cyc();
    end
    req_cmd_data_v_i = 2'b00;
    req_cmd_last_i   = 2'b00;
    #1;
    chk("wr_after_v", 64'(mem_cmd_data_v_o), 64'd0);
    chk("r0_after_last", 64'(req_cmd_header_ready_and_o), 64'd1);
    chk("r0_after_hdr", 64'(mem_cmd_header_o), 64'(H0));
    cyc();

    // one more from requester 0: FIFO = 1,0,0
    #1;
    chk("third_cmd_rdy", 64'(req_cmd_header_ready_and_o), 64'd1);
    cyc();
    req_cmd_header_v_i = 2'b00;

    mem_resp_header_v_i = 1'b1;
    mem_resp_header_i   = 64'h1111;
    #1;
    chk("resp1_tgt", 64'(req_resp_header_v_o), 64'd2);
    chk("resp1_hdr", req_resp_header_o[2*HW-1:HW], 64'h1111);
    cyc();
    mem_resp_has_data_i = 1'b1;
    #1;
    chk("resp2_tgt", 64'(req_resp_header_v_o), 64'd1);
    cyc();
    mem_resp_header_v_i = 1'b0;
    mem_resp_has_data_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_data_v_i = 1'b1;
      mem_resp_data_i   = 64'hE0 + 64'(b);
      mem_resp_last_i   = (b == 1);
      #1;
      chk("resp2_beat_v", 64'(req_resp_data_v_o), 64'd1);
      chk("resp2_beat_d", req_resp_data_o[FW-1:0], 64'hE0 + 64'(b));
      chk("resp2_beat_rdy", 64'(mem_resp_data_ready_and_o), 64'd1);
      cyc();
    end
    mem_resp_data_v_i   = 1'b0;
    mem_resp_last_i     = 1'b0;
    mem_resp_header_v_i = 1'b1;
    #1;
    chk("resp3_tgt", 64'(req_resp_header_v_o), 64'd1);
    chk("resp3_no_data_v", 64'(req_resp_data_v_o), 64'd0);
    cyc();
    mem_resp_header_v_i = 1'b0;
    #1;
    chk("empty_rdy", 64'(mem_resp_header_ready_and_o), 64'd0);

    // response backpressure from requester 0 for 3 cycles
    req_cmd_header_v_i = 2'b01;
    #1;
    chk("bp_cmd_rdy", 64'(req_cmd_header_ready_and_o), 64'd1);
    cyc();
    req_cmd_header_v_i = 2'b00;
    req_resp_header_ready_and_i = 2'b10;
    mem_resp_header_v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_rdy", 64'(mem_resp_header_ready_and_o), 64'd0);
      chk("bp_hold_v", 64'(req_resp_header_v_o), 64'd1);
      cyc();
    end
    req_resp_header_ready_and_i = 2'b11;
    #1;
    chk("bp_release_rdy", 64'(mem_resp_header_ready_and_o), 64'd1);
    cyc();
    mem_resp_header_v_i = 1'b0;
    #1;
    chk("bp_single_pop", 64'(mem_resp_header_ready_and_o), 64'd0);

    // async reset in the middle of a requester 1 write
    req_cmd_header_v_i = 2'b10;
    req_cmd_has_data_i = 2'b10;
    #1;
    chk("mid_hdr_rdy", 64'(req_cmd_header_ready_and_o), 64'd2);
    cyc();
    req_cmd_header_v_i = 2'b11;
    req_cmd_has_data_i = 2'b00;
    req_cmd_data_v_i   = 2'b10;
    req_cmd_data_i     = {64'hF00D, 64'h0};
    #1;
    chk("mid_data_v", 64'(mem_cmd_data_v_o), 64'd1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("arst_data_v", 64'(mem_cmd_data_v_o), 64'd0);
    chk("arst_data_rdy", 64'(req_cmd_data_ready_and_o), 64'd0);
    chk("arst_hdr_v", 64'(mem_cmd_header_v_o), 64'd0);
    chk("arst_hdr_rdy", 64'(req_cmd_header_ready_and_o), 64'd0);
    #2 reset_n_i = 1'b1;
    #1;
    chk("post_rst_ptr0", 64'(req_cmd_header_ready_and_o), 64'd1);
    chk("post_rst_idle", 64'(mem_cmd_data_v_o), 64'd0);
    chk("post_rst_empty", 64'(mem_resp_header_ready_and_o), 64'd0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
